// File: rtl/video_mixer.sv
// Final pixel stage: tile/sprite priority merge, colour PROM lookup, registered RGB with blanking.
// Optional shadow sprites are built when VIDEO_MIXER_SHADOW_EN is defined.
module video_mixer #(
    parameter logic [3:0] SPR_TRANSPARENT = 4'hF,
    parameter logic [3:0] RESET_CTRL      = 4'h0C
) (
    input  logic       CLK_6M,
    input  logic       rst,
    input  logic       nHBLANK,
    input  logic       nVBLANK,
    input  logic       nVSYNC,
    input  logic [7:0] DOT,
    input  logic [2:0] TPR,
    input  logic [7:0] SDOT,
    input  logic [2:0] SPR,
    input  logic       nCS,
    input  logic       nWE,
    input  logic       A,
    input  logic [7:0] D,
    output logic [9:0] pal_addr,
    input  logic [7:0] pal_rg,
    input  logic [3:0] pal_b,
    output logic [3:0] R,
    output logic [3:0] G,
    output logic [3:0] B,
    output logic       nBLANK_O,
    output logic       SRC
);

    // control register bits: {sprite_en, tile_en, bank[1:0]}
    logic [3:0] ctrl_shadow, ctrl_act;
    logic       vs_prev;
    logic       unused_d;

    assign unused_d = ^D[7:4];

    always_ff @(posedge CLK_6M or posedge rst) begin
        if (rst) begin
            ctrl_shadow <= RESET_CTRL;
            ctrl_act    <= RESET_CTRL;
            vs_prev     <= 1'b1;
        end else begin
            vs_prev <= nVSYNC;
            if (!nCS && !nWE && !A)
                ctrl_shadow <= D[3:0];
            // NBA ordering gives the pre-write shadow on a coincident write
            if (vs_prev && !nVSYNC)
                ctrl_act <= ctrl_shadow;
        end
    end

    // S0: input capture
    logic [7:0] s0_dot, s0_sdot;
    logic [2:0] s0_tpr, s0_spr;
    logic       s0_blank;

    always_ff @(posedge CLK_6M or posedge rst) begin
        if (rst) begin
            s0_dot   <= '0;
            s0_tpr   <= '0;
            s0_sdot  <= '0;
            s0_spr   <= '0;
            s0_blank <= 1'b0;
        end else begin
            s0_dot   <= DOT;
            s0_tpr   <= TPR;
            s0_sdot  <= SDOT;
            s0_spr   <= SPR;
            s0_blank <= ~(nHBLANK & nVBLANK);
        end
    end

    // S1: priority resolve
    logic       spr_win, shadow_px;
    logic [7:0] tile_idx, idx;

    always_comb begin
        spr_win   = ctrl_act[3] && (s0_sdot[3:0] != SPR_TRANSPARENT) && (s0_spr >= s0_tpr);
        tile_idx  = ctrl_act[2] ? s0_dot : 8'h00;
        shadow_px = 1'b0;
`ifdef VIDEO_MIXER_SHADOW_EN
        shadow_px = spr_win && (s0_sdot[3:0] == 4'hE);
`endif
        idx = (spr_win && !shadow_px) ? s0_sdot : tile_idx;
    end

    logic s1_src, s1_blank, s1_shadow;

    always_ff @(posedge CLK_6M or posedge rst) begin
        if (rst) begin
            pal_addr  <= '0;
            s1_src    <= 1'b0;
            s1_blank  <= 1'b0;
            s1_shadow <= 1'b0;
        end else begin
            pal_addr  <= {ctrl_act[1:0], idx};
            s1_src    <= spr_win;
            s1_blank  <= s0_blank;
            s1_shadow <= shadow_px;
        end
    end

    // S2: PROM data capture, shadow halving, blank forcing
    logic [3:0] r_n, g_n, b_n;

    always_comb begin
        r_n = pal_rg[3:0];
        g_n = pal_rg[7:4];
        b_n = pal_b;
        if (s1_shadow) begin
            r_n = {1'b0, pal_rg[3:1]};
            g_n = {1'b0, pal_rg[7:5]};
            b_n = {1'b0, pal_b[3:1]};
        end
        if (s1_blank) begin
            r_n = 4'h0;
            g_n = 4'h0;
            b_n = 4'h0;
        end
    end

    always_ff @(posedge CLK_6M or posedge rst) begin
        if (rst) begin
            R        <= '0;
            G        <= '0;
            B        <= '0;
            nBLANK_O <= 1'b0;
            SRC      <= 1'b0;
        end else begin
            R        <= r_n;
            G        <= g_n;
            B        <= b_n;
            nBLANK_O <= ~s1_blank;
            SRC      <= s1_src;
        end
    end

endmodule
